// File: rtl/servo_pwm_driver.sv
// Servo PWM generator: clamps the requested width, slew-limits it once per frame,
// and applies width/enable changes only at frame boundaries so no pulse is cut short.

module servo_pwm_driver_chk #(
   parameter int unsigned PERIOD    = 1_000_000,
   parameter int unsigned MIN_WIDTH = 50_000,
   parameter int unsigned MAX_WIDTH = 200_000
) (
   input logic        clk,
   input logic        reset,
   input logic [23:0] width_i
);
   localparam logic [23:0] PER_W = 24'(PERIOD);
   localparam logic [23:0] MIN_W = 24'(MIN_WIDTH);
   localparam logic [23:0] MAX_W = 24'(MAX_WIDTH);

   // Width in effect must stay inside the clamp window and shorter than a frame.
   a_width_legal: assert property (@(posedge clk) disable iff (reset)
      (width_i >= MIN_W) && (width_i <= MAX_W) && (width_i < PER_W));
endmodule

module servo_pwm_driver #(
   parameter int unsigned PERIOD     = 1_000_000,
   parameter int unsigned MIN_WIDTH  = 50_000,
   parameter int unsigned MAX_WIDTH  = 200_000,
   parameter int unsigned STEP       = 500,
   parameter int unsigned INIT_WIDTH = 120_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] target_width,
   input  logic        enable,
   output logic        pwm_out,
   output logic [23:0] current_width,
   output logic        at_target,
   output logic        frame_start
);
   localparam logic [19:0]        CNT_LAST   = 20'(PERIOD - 1);
   localparam logic [23:0]        MIN_W      = 24'(MIN_WIDTH);
   localparam logic [23:0]        MAX_W      = 24'(MAX_WIDTH);
   localparam logic [23:0]        INIT_W     = 24'(INIT_WIDTH);
   localparam logic [23:0]        STEP_W     = 24'(STEP);
   localparam logic signed [24:0] STEP_S     = 25'(STEP);
   localparam logic signed [24:0] STEP_NEG_S = -STEP_S;

   localparam logic [1:0] ST_DISABLED = 2'd0;
   localparam logic [1:0] ST_RAMPING  = 2'd1;
   localparam logic [1:0] ST_TRACKING = 2'd2;

   logic [19:0]        cnt_q, cnt_d;
   logic [23:0]        width_q, width_d;
   logic [1:0]         state_q, state_d;
   logic               pwm_q, pwm_d;
   logic               at_target_q, at_target_d;
   logic               frame_start_q, frame_start_d;
   logic [23:0]        tgt_c_s;
   logic               boundary_s;
   logic signed [24:0] diff_s;

   // Next-state: frame counter, clamp, slew-limited width update at the boundary.
   always_comb begin
      boundary_s = (cnt_q == CNT_LAST);
      cnt_d      = boundary_s ? 20'd0 : cnt_q + 20'd1;

      if (target_width < MIN_W) begin
         tgt_c_s = MIN_W;
      end else if (target_width > MAX_W) begin
         tgt_c_s = MAX_W;
      end else begin
         tgt_c_s = target_width;
      end
      diff_s = $signed({1'b0, tgt_c_s}) - $signed({1'b0, width_q});

      width_d = width_q;
      state_d = state_q;
      if (boundary_s) begin
         if (!enable) begin
            state_d = ST_DISABLED;
         end else if (diff_s > STEP_S) begin
            width_d = width_q + STEP_W;
            state_d = ST_RAMPING;
         end else if (diff_s < STEP_NEG_S) begin
            width_d = width_q - STEP_W;
            state_d = ST_RAMPING;
         end else begin
            width_d = tgt_c_s;
            state_d = ST_TRACKING;
         end
      end else begin
         state_d = state_q;
      end

      // state only moves at the boundary, so it doubles as the registered drive flag
      pwm_d         = (state_q != ST_DISABLED) && ({4'd0, cnt_q} < width_q);
      at_target_d   = (state_d == ST_TRACKING);
      frame_start_d = boundary_s;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q         <= 20'd0;
         width_q       <= INIT_W;
         state_q       <= ST_DISABLED;
         pwm_q         <= 1'b0;
         at_target_q   <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         width_q       <= width_d;
         state_q       <= state_d;
         pwm_q         <= pwm_d;
         at_target_q   <= at_target_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pwm_out       = pwm_q;
   assign current_width = width_q;
   assign at_target     = at_target_q;
   assign frame_start   = frame_start_q;

   servo_pwm_driver_chk #(
      .PERIOD    (PERIOD),
      .MIN_WIDTH (MIN_WIDTH),
      .MAX_WIDTH (MAX_WIDTH)
   ) u_chk (
      .clk     (clk),
      .reset   (reset),
      .width_i (width_q)
   );
endmodule

// File: tb/tb_servo_pwm_driver.sv
// Self-checking bench for servo_pwm_driver: directed scenarios plus randomized frames,
// compared against a frame-level reference model built from clamp/step arithmetic.

module tb_servo_pwm_driver;
   localparam int PERIOD = 100;
   localparam int MINW   = 10;
   localparam int MAXW   = 60;
   localparam int STEP   = 4;
   localparam int INIT   = 30;

   logic        clk = 1'b0;
   logic        reset, enable, pwm_out, at_target, frame_start;
   logic [23:0] target_width, current_width;

   int errors = 0;
   int checks = 0;

   // reference model state
   int   m_cnt, m_width;
   logic m_active, m_at, m_pwm, m_fs;

   // per-frame observations
   int   hi, mhi, w, mw, bad;
   logic at, mat;

   servo_pwm_driver #(
      .PERIOD(PERIOD), .MIN_WIDTH(MINW), .MAX_WIDTH(MAXW), .STEP(STEP), .INIT_WIDTH(INIT)
   ) dut (
      .clk(clk), .reset(reset), .target_width(target_width), .enable(enable),
      .pwm_out(pwm_out), .current_width(current_width), .at_target(at_target),
      .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   function automatic int clampw(input int t);
      return (t < MINW) ? MINW : ((t > MAXW) ? MAXW : t);
   endfunction

   function automatic int step_to(input int cur, input int tgt);
      if (tgt - cur > STEP)      return cur + STEP;
      else if (cur - tgt > STEP) return cur - STEP;
      else                       return tgt;
   endfunction

   // Reference model: one frame = PERIOD ticks, decisions taken on the last tick.
   always @(posedge clk) begin
      if (reset) begin
         m_cnt <= 0; m_width <= INIT; m_active <= 1'b0;
         m_at <= 1'b0; m_pwm <= 1'b0; m_fs <= 1'b0;
      end else begin
         m_cnt <= (m_cnt == PERIOD - 1) ? 0 : m_cnt + 1;
         m_fs  <= (m_cnt == PERIOD - 1);
         m_pwm <= m_active && (m_cnt < m_width);
         if (m_cnt == PERIOD - 1) begin
            if (enable) begin
               m_width  <= step_to(m_width, clampw(int'(target_width)));
               m_active <= 1'b1;
               m_at     <= (step_to(m_width, clampw(int'(target_width))) == clampw(int'(target_width)));
            end else begin
               m_active <= 1'b0;
               m_at     <= 1'b0;
            end
         end
      end
   end

   // Advance one full frame from a cnt==0 negedge to the next; mode selects mid-frame stimulus.
   task automatic run_frame(input int mode, output int o_hi, output int o_mhi, output int o_w,
                            output int o_mw, output logic o_at, output logic o_mat, output int o_bad);
      o_hi = 0; o_mhi = 0; o_bad = 0;
      o_w = int'(current_width); o_mw = m_width; o_at = at_target; o_mat = m_at;
      for (int k = 1; k <= PERIOD; k++) begin
         case (mode)
            1: target_width = (k == PERIOD) ? 24'd40 : ((k % 2 == 1) ? 24'd20 : 24'd55);
            2: if (k == 16) enable = 1'b0;
            3: target_width = (k == PERIOD) ? 24'($urandom_range(0, 300)) : 24'($urandom);
            default: ;
         endcase
         @(negedge clk);
         if (pwm_out === 1'b1) o_hi++;
         if (m_pwm) o_mhi++;
         if ({pwm_out, at_target, frame_start} !== {m_pwm, m_at, m_fs} ||
             int'(current_width) != m_width) o_bad++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; target_width = 24'd30;
      repeat (3) @(negedge clk);
      checks++;
      if ({pwm_out, at_target, frame_start} !== 3'b000 || current_width !== 24'd30) begin
         errors++;
         $display("FAIL reset: pwm=%b at=%b fs=%b width=%0d, expected 0 0 0 30",
                  pwm_out, at_target, frame_start, current_width);
      end
      reset = 1'b0;
   endtask

   task automatic test_track();
      int ew[2] = '{30, 30};
      int eh[2] = '{0, 30};
      logic ea[2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         run_frame(0, hi, mhi, w, mw, at, mat, bad);
         checks++;
         if (w != ew[i] || hi != eh[i] || at !== ea[i] || bad != 0 || hi != mhi) begin
            errors++;
            $display("FAIL track[%0d]: width=%0d high=%0d at=%b bad=%0d, expected %0d %0d %b 0",
                     i, w, hi, at, bad, ew[i], eh[i], ea[i]);
         end
      end
   endtask

   task automatic test_ramp_up();
      int ew[5] = '{30, 34, 38, 42, 45};
      logic ea[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      target_width = 24'd45;
      for (int i = 0; i < 5; i++) begin
         run_frame(0, hi, mhi, w, mw, at, mat, bad);
         checks++;
         if (w != ew[i] || hi != ew[i] || at !== ea[i] || bad != 0) begin
            errors++;
            $display("FAIL ramp_up[%0d]: width=%0d high=%0d at=%b bad=%0d, expected %0d %0d %b 0",
                     i, w, hi, at, bad, ew[i], ew[i], ea[i]);
         end
      end
   endtask

   task automatic test_clamp();
      int lo, hi_w;
      target_width = 24'd200;
      lo = 1000; hi_w = 0;
      for (int i = 0; i < 6; i++) begin
         run_frame(0, hi, mhi, w, mw, at, mat, bad);
         if (w < lo) lo = w;
         if (w > hi_w) hi_w = w;
      end
      checks++;
      if (w != 60 || at !== 1'b1 || hi != 60 || hi_w > MAXW || bad != 0) begin
         errors++;
         $display("FAIL clamp_high: width=%0d at=%b high=%0d max=%0d bad=%0d, expected 60 1 60 <=60 0",
                  w, at, hi, hi_w, bad);
      end
      target_width = 24'd0;
      for (int i = 0; i < 15; i++) begin
         run_frame(0, hi, mhi, w, mw, at, mat, bad);
         if (w < lo) lo = w;
      end
      checks++;
      if (w != 10 || at !== 1'b1 || hi != 10 || lo < MINW || bad != 0) begin
         errors++;
         $display("FAIL clamp_low: width=%0d at=%b high=%0d min=%0d bad=%0d, expected 10 1 10 >=10 0",
                  w, at, hi, lo, bad);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) begin
         enable = ($urandom_range(0, 3) != 0);
         target_width = 24'($urandom_range(0, 255));
         run_frame(($urandom_range(0, 1) == 1) ? 3 : 0, hi, mhi, w, mw, at, mat, bad);
         checks++;
         if (bad != 0 || hi != mhi || w != mw || at !== mat || w < MINW || w > MAXW) begin
            errors++;
            $display("FAIL random[%0d]: width=%0d high=%0d at=%b bad=%0d, expected %0d %0d %b 0",
                     i, w, hi, at, bad, mw, mhi, mat);
         end
      end
   endtask

   task automatic test_enable_drop();
      enable = 1'b1; target_width = 24'd30;
      for (int i = 0; i < 20; i++) run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 30 || at !== 1'b1) begin
         errors++;
         $display("FAIL settle30: width=%0d at=%b, expected 30 1", w, at);
      end
      run_frame(2, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 30 || hi != 30 || bad != 0) begin
         errors++;
         $display("FAIL drop_pulse: width=%0d high=%0d bad=%0d, expected 30 30 0", w, hi, bad);
      end
      enable = 1'b1; target_width = 24'd50;
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 30 || hi != 0 || at !== 1'b0 || bad != 0) begin
         errors++;
         $display("FAIL disabled: width=%0d high=%0d at=%b bad=%0d, expected 30 0 0 0", w, hi, at, bad);
      end
      target_width = 24'd30;
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 34 || hi != 34 || at !== 1'b0 || bad != 0) begin
         errors++;
         $display("FAIL resume: width=%0d high=%0d at=%b bad=%0d, expected 34 34 0 0", w, hi, at, bad);
      end
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 30 || hi != 30 || at !== 1'b1 || bad != 0) begin
         errors++;
         $display("FAIL back30: width=%0d high=%0d at=%b bad=%0d, expected 30 30 1 0", w, hi, at, bad);
      end
   endtask

   task automatic test_boundary_sample();
      run_frame(1, hi, mhi, w, mw, at, mat, bad);
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 34 || hi != 34 || at !== 1'b0 || bad != 0) begin
         errors++;
         $display("FAIL boundary_sample: width=%0d high=%0d at=%b bad=%0d, expected 34 34 0 0",
                  w, hi, at, bad);
      end
   endtask

   task automatic test_reset_mid();
      repeat (10) @(negedge clk);
      checks++;
      if (pwm_out !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_pulse: pwm=%b, expected 1", pwm_out);
      end
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({pwm_out, at_target, frame_start} !== 3'b000 || current_width !== 24'd30) begin
         errors++;
         $display("FAIL reset_mid: pwm=%b at=%b fs=%b width=%0d, expected 0 0 0 30",
                  pwm_out, at_target, frame_start, current_width);
      end
      reset = 1'b0;
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 30 || hi != 0 || at !== 1'b0 || bad != 0) begin
         errors++;
         $display("FAIL post_reset: width=%0d high=%0d at=%b bad=%0d, expected 30 0 0 0", w, hi, at, bad);
      end
      run_frame(0, hi, mhi, w, mw, at, mat, bad);
      checks++;
      if (w != 34 || hi != 34 || at !== 1'b0 || bad != 0) begin
         errors++;
         $display("FAIL post_reset_ramp: width=%0d high=%0d at=%b bad=%0d, expected 34 34 0 0",
                  w, hi, at, bad);
      end
   endtask

   initial begin
      test_reset();
      test_track();
      test_ramp_up();
      test_clamp();
      test_random();
      test_enable_drop();
      test_boundary_sample();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
